// File: rtl/packet_buffer_pkg.sv
// Shared types and default sizes for the packet-buffer read side.
package packet_buffer_pkg;

  localparam int unsigned PB_NUM_LANES      = 4;
  localparam int unsigned PB_AXI_WIDTH      = 64;
  localparam int unsigned PB_LANE_IDX_WIDTH = 2;
  localparam int unsigned PB_STATS_WIDTH    = 32;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_XFER = 1'b1
  } rd_arb_state_e;

endpackage : packet_buffer_pkg

// File: rtl/packet_buffer_rr_select.sv
// Round-robin lane picker: first valid lane after rr_ptr, wrapping, rr_ptr itself last.
module packet_buffer_rr_select
  import packet_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES = PB_NUM_LANES,
  parameter int unsigned IDX_WIDTH = PB_LANE_IDX_WIDTH
) (
  input  logic [NUM_LANES-1:0] valid_vec,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  output logic [IDX_WIDTH-1:0] grant_idx_c,
  output logic                 grant_valid_c
);

  int lane;

  // Scan offsets from farthest to nearest so the nearest valid lane wins.
  always_comb begin
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    lane          = 0;
    for (int off = int'(NUM_LANES); off >= 1; off--) begin
      lane = (int'(rr_ptr) + off) % int'(NUM_LANES);
      if (valid_vec[IDX_WIDTH'(lane)]) begin
        grant_idx_c   = IDX_WIDTH'(lane);
        grant_valid_c = 1'b1;
      end
    end
  end

endmodule : packet_buffer_rr_select

// File: rtl/packet_buffer_read_arbiter.sv
// Drains NUM_LANES lane FIFOs onto one AXI-stream egress port with
// packet-granular round-robin grants and a single registered output stage.
// Optional per-lane packet counters: define PACKET_BUFFER_READ_STATS_EN.
module packet_buffer_read_arbiter
  import packet_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES             = PB_NUM_LANES,
  parameter int unsigned AXI_WIDTH             = PB_AXI_WIDTH,
  parameter int unsigned LANE_SELECT_IDX_WIDTH = PB_LANE_IDX_WIDTH
`ifdef PACKET_BUFFER_READ_STATS_EN
  ,
  parameter int unsigned STATS_WIDTH           = PB_STATS_WIDTH
`endif
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_LANES-1:0][AXI_WIDTH-1:0]  lane_tdata_i,
  input  logic [NUM_LANES-1:0]                 lane_tvalid_i,
  input  logic [NUM_LANES-1:0]                 lane_tlast_i,
  output logic [NUM_LANES-1:0]                 lane_tready_o,
  output logic [AXI_WIDTH-1:0]                 m_tdata_o,
  output logic                                 m_tvalid_o,
  output logic                                 m_tlast_o,
  output logic [LANE_SELECT_IDX_WIDTH-1:0]     m_lane_o,
  input  logic                                 m_tready_i
`ifdef PACKET_BUFFER_READ_STATS_EN
  ,
  output logic [NUM_LANES-1:0][STATS_WIDTH-1:0] pkt_count_o
`endif
);

  localparam int unsigned IDX_W = LANE_SELECT_IDX_WIDTH;

  rd_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_idx_c;
  logic             sel_valid_c;
  logic             out_ready_c;
  logic             accept_c;

  packet_buffer_rr_select #(
    .NUM_LANES (NUM_LANES),
    .IDX_WIDTH (IDX_W)
  ) u_rr_select (
    .valid_vec     (lane_tvalid_i),
    .rr_ptr        (rr_ptr_q),
    .grant_idx_c   (sel_idx_c),
    .grant_valid_c (sel_valid_c)
  );

  // State, round-robin pointer and current grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RD_IDLE;
      rr_ptr_q <= IDX_W'(NUM_LANES - 1);
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Arbitrate in IDLE; in XFER pop the granted lane while the output stage can take a beat.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    lane_tready_o = '0;
    accept_c      = 1'b0;
    out_ready_c   = !m_tvalid_o || m_tready_i;
    case (state_q)
      RD_IDLE: begin
        if (sel_valid_c) begin
          grant_d  = sel_idx_c;
          rr_ptr_d = sel_idx_c;
          state_d  = RD_XFER;
        end
      end
      RD_XFER: begin
        lane_tready_o[grant_q] = out_ready_c;
        accept_c               = out_ready_c && lane_tvalid_i[grant_q];
        if (accept_c && lane_tlast_i[grant_q]) begin
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Egress register: load on accept, otherwise drain on downstream ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_tdata_o  <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_lane_o   <= '0;
    end else if (accept_c) begin
      m_tdata_o  <= lane_tdata_i[grant_q];
      m_tvalid_o <= 1'b1;
      m_tlast_o  <= lane_tlast_i[grant_q];
      m_lane_o   <= grant_q;
    end else if (m_tready_i) begin
      m_tvalid_o <= 1'b0;
    end
  end

`ifdef PACKET_BUFFER_READ_STATS_EN
  // Count packets leaving per source lane, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_count_o <= '0;
    end else if (m_tvalid_o && m_tready_i && m_tlast_o &&
                 (pkt_count_o[m_lane_o] != '1)) begin
      pkt_count_o[m_lane_o] <= pkt_count_o[m_lane_o] + STATS_WIDTH'(1);
    end
  end
`endif

endmodule : packet_buffer_read_arbiter
